// File: rtl/banked_dp_ram.sv
// True dual-port RAM split into 2**BANK_BITS banks, with a post-reset clear sequencer.
// Optional macro RAM_OUT_REG_EN adds one output register stage per port (latency 2).
module banked_dp_ram #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    BANK_BITS   = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] q_a,
    output logic                  rvalid_a,
    input  logic                  en_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] q_b,
    output logic                  rvalid_b,
    output logic                  busy
);
    localparam int NUM_BANKS  = 1 << BANK_BITS;
    localparam int OFF_W      = ADDR_WIDTH - BANK_BITS;
    localparam int BANK_DEPTH = 1 << OFF_W;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t           state_q, state_d;
    logic [OFF_W-1:0] clr_cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_CLEAR) clr_cnt_q <= clr_cnt_q + 1'b1;
        end
    end

    // NOTE: next-state defaults to the current state first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        if (state_q == ST_CLEAR && clr_cnt_q == {OFF_W{1'b1}}) state_d = ST_READY;
    end

    assign busy = (state_q == ST_CLEAR);

    logic [BANK_BITS-1:0] bank_a, bank_b, sel_a_q, sel_b_q;
    logic [OFF_W-1:0]     off_a, off_b;
    logic                 acc_a, acc_b, wr_a, wr_b;
    logic                 rvalid_a_int, rvalid_b_int;
    logic [DATA_WIDTH-1:0] q_a_int, q_b_int;
    logic [DATA_WIDTH-1:0] bank_q_a [NUM_BANKS];
    logic [DATA_WIDTH-1:0] bank_q_b [NUM_BANKS];

    assign bank_a = addr_a[ADDR_WIDTH-1 -: BANK_BITS];
    assign bank_b = addr_b[ADDR_WIDTH-1 -: BANK_BITS];
    assign off_a  = addr_a[OFF_W-1:0];
    assign off_b  = addr_b[OFF_W-1:0];
    assign acc_a  = en_a & ~busy;
    assign acc_b  = en_b & ~busy;
    assign wr_a   = acc_a & we_a;
    assign wr_b   = acc_b & we_b;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [BANK_DEPTH];
        logic [DATA_WIDTH-1:0] rq_a, rq_b;
        logic                  hit_a, hit_b;

        assign hit_a = (bank_a == BANK_BITS'(b));
        assign hit_b = (bank_b == BANK_BITS'(b));

        // NOTE: the array itself has no reset; the clear sequencer initialises it instead.
        always_ff @(posedge clk) begin
            if (busy) begin
                mem[clr_cnt_q] <= CLEAR_VALUE;
            end else begin
                if (wr_a && hit_a) mem[off_a] <= data_a;
                // Port A wins a same-address double write.
                if (wr_b && hit_b && !(wr_a && hit_a && off_a == off_b)) mem[off_b] <= data_b;
            end
        end

        // Per-bank read registers: write-first on the own port, old data across ports.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rq_a <= '0;
                rq_b <= '0;
            end else begin
                if (acc_a && hit_a) rq_a <= we_a ? data_a : mem[off_a];
                if (acc_b && hit_b) rq_b <= we_b ? data_b : mem[off_b];
            end
        end

        assign bank_q_a[b] = rq_a;
        assign bank_q_b[b] = rq_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a_q      <= '0;
            sel_b_q      <= '0;
            rvalid_a_int <= 1'b0;
            rvalid_b_int <= 1'b0;
        end else begin
            if (acc_a) sel_a_q <= bank_a;
            if (acc_b) sel_b_q <= bank_b;
            rvalid_a_int <= acc_a & ~we_a;
            rvalid_b_int <= acc_b & ~we_b;
        end
    end

    // Bank index captured with the request keeps data aligned to the bank it came from.
    assign q_a_int = bank_q_a[sel_a_q];
    assign q_b_int = bank_q_b[sel_b_q];

`ifdef RAM_OUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_a      <= '0;
            q_b      <= '0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
        end else begin
            q_a      <= q_a_int;
            q_b      <= q_b_int;
            rvalid_a <= rvalid_a_int;
            rvalid_b <= rvalid_b_int;
        end
    end
`else
    assign q_a      = q_a_int;
    assign q_b      = q_b_int;
    assign rvalid_a = rvalid_a_int;
    assign rvalid_b = rvalid_b_int;
`endif

endmodule

// File: tb/tb_banked_dp_ram.sv
// Directed bench for banked_dp_ram: default 2x512 instance plus a 4x64 instance.
module tb_banked_dp_ram;
`ifdef RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        en_a, we_a, rvalid_a, en_b, we_b, rvalid_b, busy;
    logic [9:0]  addr_a, addr_b;
    logic [15:0] data_a, data_b, q_a, q_b;

    logic        en_s, we_s, rvalid_s, rvalid_sb, busy_s;
    logic [7:0]  addr_s;
    logic [15:0] data_s, q_s, q_sb;

    int errors = 0;
    int checks = 0;

    banked_dp_ram dut (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .data_a(data_a), .q_a(q_a), .rvalid_a(rvalid_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .data_b(data_b), .q_b(q_b), .rvalid_b(rvalid_b),
        .busy(busy)
    );

    banked_dp_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .BANK_BITS(2)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_s), .we_a(we_s), .addr_a(addr_s), .data_a(data_s), .q_a(q_s), .rvalid_a(rvalid_s),
        .en_b(1'b0), .we_b(1'b0), .addr_b(8'h00), .data_b(16'h0000), .q_b(q_sb), .rvalid_b(rvalid_sb),
        .busy(busy_s)
    );

    task automatic idle();
        en_a = 0; we_a = 0; en_b = 0; we_b = 0; en_s = 0; we_s = 0;
    endtask

    task automatic get_port(input int port, output logic [15:0] q, output logic rv);
        case (port)
            0:       begin q = q_a; rv = rvalid_a; end
            1:       begin q = q_b; rv = rvalid_b; end
            default: begin q = q_s; rv = rvalid_s; end
        endcase
    endtask

    task automatic set_req(input int port, input logic en, input logic we,
                           input logic [9:0] addr, input logic [15:0] data);
        case (port)
            0:       begin en_a = en; we_a = we; addr_a = addr; data_a = data; end
            1:       begin en_b = en; we_b = we; addr_b = addr; data_b = data; end
            default: begin en_s = en; we_s = we; addr_s = addr[7:0]; data_s = data; end
        endcase
    endtask

    task automatic wait_clear(output int n_main, output int n_small);
        int n = 0;
        n_small = -1;
        while ((busy || busy_s) && n < 2000) begin
            @(negedge clk);
            n++;
            if (!busy_s && n_small < 0) n_small = n;
        end
        n_main = busy ? -1 : n;
    endtask

    task automatic rd(input int port, input logic [9:0] addr, input logic [15:0] exp, input string name);
        logic [15:0] q;
        logic        rv;
        set_req(port, 1'b1, 1'b0, addr, 16'h0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 1) set_req(port, 1'b0, 1'b0, addr, 16'h0);
            get_port(port, q, rv);
            if (k < LAT) begin
                checks++;
                if (rv !== 1'b0) begin errors++; $display("FAIL %s early_rvalid got=%b want=0", name, rv); end
            end
        end
        checks++;
        if (rv !== 1'b1) begin errors++; $display("FAIL %s rvalid got=%b want=1", name, rv); end
        checks++;
        if (q !== exp) begin errors++; $display("FAIL %s q got=%h want=%h", name, q, exp); end
        @(negedge clk);
        get_port(port, q, rv);
        checks++;
        if (rv !== 1'b0) begin errors++; $display("FAIL %s rvalid_one_cycle got=%b want=0", name, rv); end
    endtask

    task automatic wr(input int port, input logic [9:0] addr, input logic [15:0] data, input string name);
        logic [15:0] q;
        logic        rv;
        set_req(port, 1'b1, 1'b1, addr, data);
        @(negedge clk);
        set_req(port, 1'b0, 1'b0, addr, data);
        for (int k = 2; k <= LAT; k++) @(negedge clk);
        get_port(port, q, rv);
        checks++;
        if (q !== data || rv !== 1'b0)
            begin errors++; $display("FAIL %s write_first q=%h rvalid=%b want q=%h rvalid=0", name, q, rv, data); end
    endtask

    task automatic test_reset();
        int n, ns;
        idle();
        addr_a = '0; addr_b = '0; data_a = '0; data_b = '0; addr_s = '0; data_s = '0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || busy_s !== 1'b1)
            begin errors++; $display("FAIL reset_busy got=%b/%b want=1/1", busy, busy_s); end
        checks++;
        if (q_a !== 16'h0 || q_b !== 16'h0 || rvalid_a !== 1'b0 || rvalid_b !== 1'b0)
            begin errors++; $display("FAIL reset_outputs q_a=%h q_b=%h rv=%b%b want 0", q_a, q_b, rvalid_a, rvalid_b); end
        rst_n = 1'b1;
        wait_clear(n, ns);
        checks++;
        if (n !== 512) begin errors++; $display("FAIL clear_len got=%0d want=512", n); end
        checks++;
        if (ns !== 64) begin errors++; $display("FAIL clear_len_small got=%0d want=64", ns); end
        rd(0, 10'h000, 16'h0000, "clear_rd_000");
        rd(0, 10'h3FF, 16'h0000, "clear_rd_3ff");
        rd(1, 10'h1FF, 16'h0000, "clear_rd_b_1ff");
    endtask

    task automatic test_bank_isolation();
        wr(0, 10'h005, 16'h1234, "iso_wr_a");
        wr(1, 10'h205, 16'hABCD, "iso_wr_b");
        rd(0, 10'h005, 16'h1234, "iso_rd_005");
        rd(0, 10'h205, 16'hABCD, "iso_rd_205");
        rd(1, 10'h006, 16'h0000, "iso_rd_006");
    endtask

    task automatic test_registered_bank();
        en_a = 1; we_a = 0; addr_a = 10'h005;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            if (k == 1) addr_a = 10'h205;
            if (k == 2) begin en_a = 0; addr_a = 10'h005; end
            #1;
            if (k == LAT) begin
                checks++;
                if (q_a !== 16'h1234 || rvalid_a !== 1'b1)
                    begin errors++; $display("FAIL regbank_first q=%h rv=%b want 1234/1", q_a, rvalid_a); end
            end
            if (k == LAT + 1) begin
                checks++;
                if (q_a !== 16'hABCD || rvalid_a !== 1'b1)
                    begin errors++; $display("FAIL regbank_second q=%h rv=%b want abcd/1", q_a, rvalid_a); end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_collision();
        en_a = 1; we_a = 1; addr_a = 10'h010; data_a = 16'h1111;
        en_b = 1; we_b = 1; addr_b = 10'h010; data_b = 16'h2222;
        @(negedge clk);
        idle();
        for (int k = 2; k <= LAT; k++) @(negedge clk);
        rd(0, 10'h010, 16'h1111, "coll_ww");
        en_a = 1; we_a = 1; addr_a = 10'h010; data_a = 16'h3333;
        en_b = 1; we_b = 0; addr_b = 10'h010;
        @(negedge clk);
        idle();
        for (int k = 2; k <= LAT; k++) @(negedge clk);
        checks++;
        if (q_b !== 16'h1111 || rvalid_b !== 1'b1)
            begin errors++; $display("FAIL coll_wr_old q_b=%h rv=%b want 1111/1", q_b, rvalid_b); end
        checks++;
        if (q_a !== 16'h3333 || rvalid_a !== 1'b0)
            begin errors++; $display("FAIL coll_wr_wf q_a=%h rv=%b want 3333/0", q_a, rvalid_a); end
        @(negedge clk);
        rd(1, 10'h010, 16'h3333, "coll_rd_new");
    endtask

    task automatic test_busy_restart();
        int n, ns;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_clear_busy got=%b want=1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 3) begin
                en_a = 1; we_a = 1; addr_a = 10'h007; data_a = 16'hDEAD;
                en_b = 1; we_b = 1; addr_b = 10'h207; data_b = 16'hBEEF;
            end else begin
                we_a = 0; we_b = 0;
            end
            @(negedge clk);
        end
        checks++;
        if (rvalid_a !== 1'b0 || rvalid_b !== 1'b0 || busy !== 1'b1)
            begin errors++; $display("FAIL busy_ignore rv=%b%b busy=%b want 00/1", rvalid_a, rvalid_b, busy); end
        idle();
        wait_clear(n, ns);
        checks++;
        if (n !== 507) begin errors++; $display("FAIL restart_len got=%0d want=507", n); end
        rd(0, 10'h007, 16'h0000, "busy_wr_a_dropped");
        rd(1, 10'h207, 16'h0000, "busy_wr_b_dropped");
        rd(0, 10'h005, 16'h0000, "restart_cleared");
    endtask

    task automatic test_small();
        wr(2, 10'h0C3, 16'h00AA, "small_wr");
        rd(2, 10'h0C3, 16'h00AA, "small_rd_c3");
        rd(2, 10'h003, 16'h0000, "small_rd_03");
        rd(2, 10'h083, 16'h0000, "small_rd_83");
    endtask

    initial begin
        test_reset();
        test_bank_isolation();
        test_registered_bank();
        test_collision();
        test_small();
        test_busy_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/banked_dp_ram.md
Name: banked_dp_ram

Overview:
- True dual-port synchronous RAM split into 2**BANK_BITS banks.
- The upper BANK_BITS address bits select the bank. Writes go to the addressed bank only.
- The read-data mux uses a registered bank index, so data and bank stay aligned.
- After every reset, a hardware clear sequencer fills the whole memory with CLEAR_VALUE before accepting traffic.
- Sits between the CPU datapath/memory controller and the data memory; successor to the fixed two-bank 16x1024 memory.

Parameters:
- DATA_WIDTH, 16, word width in bits.
- ADDR_WIDTH, 10, total word address width; total depth 2**ADDR_WIDTH.
- BANK_BITS, 1, bank-select bits (1..ADDR_WIDTH-1); NUM_BANKS = 2**BANK_BITS; bank depth = 2**(ADDR_WIDTH-BANK_BITS).
- CLEAR_VALUE, 0, word written to every location by the clear sequencer.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en_a  in  1  port A access request.
- we_a  in  1  port A write (qualified by en_a).
- addr_a  in  ADDR_WIDTH  port A word address.
- data_a  in  DATA_WIDTH  port A write data.
- q_a  out  DATA_WIDTH  port A read data.
- rvalid_a  out  1  q_a holds the result of a port A read.
- en_b, we_b, addr_b, data_b, q_b, rvalid_b: port B equivalents, same widths.
- busy  out  1  clear sequence in progress; all requests ignored.

Behaviour:
- Reset (rst_n=0, async): q_a=q_b=0, rvalid_a=rvalid_b=0, busy=1, FSM=CLEAR, clear counter=0. Memory contents are not reset directly.
- FSM states CLEAR and READY.
- CLEAR:
  - Each cycle, writes CLEAR_VALUE at bank offset = counter in all banks in parallel, then increments the counter.
  - On the cycle the counter equals 2**(ADDR_WIDTH-BANK_BITS)-1, goes to READY next edge and busy drops.
  - Total duration is exactly 2**(ADDR_WIDTH-BANK_BITS) cycles after rst_n rises.
- READY persists until the next reset. rst_n asserted mid-clear aborts and restarts the clear from offset 0.
- While busy=1, en_a/en_b are ignored: no write, no read, rvalid stays 0.
- Bank decode: bank = addr[ADDR_WIDTH-1 -: BANK_BITS], offset = addr[ADDR_WIDTH-BANK_BITS-1:0].
- Write: en & we & !busy writes data to (bank, offset) only. Other banks are untouched.
- Read (en & !we & !busy):
  - Latency 1. q and rvalid update at the next edge, with rvalid=1 for exactly that one cycle per read.
  - The bank index is registered with the request. q selects the bank captured at request time, not the current addr.
- Write on a port: q of that port shows the new data next cycle (write-first), and rvalid stays 0 for writes.
- q holds its last value when there is no new read.
- Cross-port collisions, same full address, same cycle:
  - Both writing: port A data is stored.
  - One port writing, the other reading: the reader gets the old data.
- Different banks or different offsets: fully independent, no stall.
- Address is full-range; no out-of-range condition exists.

Optional Feature:
- Macro RAM_OUT_REG_EN.
- Defined: adds one output register stage per port. q and rvalid appear 2 cycles after the request, reset to 0 with rst_n, and all other rules are unchanged.
- Undefined: latency 1 as above.

Test Plan:
- Reset then idle, defaults (BANK_BITS=1, ADDR_WIDTH=10): busy=1 for exactly 512 cycles after rst_n rises, then 0. A read of 0x000 and 0x3FF returns 0x0000 with rvalid one cycle later.
- Port A writes 0x1234 @0x005; port B writes 0xABCD @0x205 (other bank); read both from A on consecutive cycles -> q_a=0x1234 then 0xABCD. Confirms only the addressed bank was written.
- Read @0x005 cycle N, then @0x205 cycle N+1 -> q_a=0x1234 at N+1 and 0xABCD at N+2, independent of addr_a after request. Confirms the registered bank select.
- Same cycle, A writes 0x1111 and B writes 0x2222 @0x010 -> a later read gives 0x1111. A writes 0x3333 while B reads @0x010 -> q_b=0x1111, and the next B read gives 0x3333.
- Assert rst_n low at clear cycle 200, release -> busy stays 1 for a full 512 cycles again. Writes attempted while busy have no effect (location still 0x0000).
- BANK_BITS=2, ADDR_WIDTH=8, RAM_OUT_REG_EN defined: clear lasts 64 cycles. Write 0x00AA @0xC3, then read it -> q_a=0x00AA with rvalid_a two cycles after the request.
